axi_rd_burst_ctrl: RTL and testbench
====================================

Name: axi_rd_burst_ctrl

Overview:
- AXI read-address burst sequencer that sits directly upstream of the burst address-decode stage.
- Accepts one AR transaction at a time and latches len/size/burst.
- Drives the decode stage's select/addr/size inputs so its registered address output tracks the current beat address.
- Sequences beats to the read-data path with a valid/ready handshake and generates last.

Parameters:
- ADDR_W, 32, address width; must equal the decode stage width.
- MAX_SIZE, 2, largest legal ar_size (log2 of data bus bytes); 2 means a 32-bit bus.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ar_valid  in  1  AR request valid.
- ar_ready  out  1  AR accept; high only in IDLE.
- ar_addr  in  ADDR_W  burst start address.
- ar_len  in  8  beats minus one.
- ar_size  in  3  bytes per beat = 1<<ar_size.
- ar_burst  in  2  00 FIXED, 01 INCR, 10/11 unsupported.
- dec_select  out  1  to decode stage: 1 = increment, 0 = load dec_addr.
- dec_addr  out  ADDR_W  to decode stage: load value.
- dec_size  out  3  to decode stage: latched size.
- beat_valid  out  1  a beat is presented; the decode stage output holds its address this cycle.
- beat_ready  in  1  downstream consumes the beat.
- beat_last  out  1  final beat of the burst.
- beat_idx  out  8  beat number, 0..len.
- beat_err  out  1  burst is unsupported or has an illegal size; qualifies every beat of that burst.

Behaviour:
- States:
  - IDLE: ar_ready=1.
  - BURST: beat_valid=1.
- Reset (rst=1 at edge): state IDLE; internal len/size/burst/cur_addr/beat_idx/err regs cleared to 0.
  - Outputs while in reset state: beat_valid=0, beat_last=0, beat_err=0, beat_idx=0, dec_select=0, dec_size=0.
  - ar_ready reads 0 while rst is high and 1 from the first cycle after release.
  - A reset mid-burst abandons the burst: no further beats, no last.
- IDLE:
  - dec_select=0 and dec_addr=ar_addr (combinational pass-through), so the decode stage loads the start address on the accepting edge.
  - On ar_valid&ar_ready: latch cur_addr=ar_addr, len, size, burst; beat_idx=0; go to BURST.
  - err=1 if ar_burst is not in {00,01} or ar_size>MAX_SIZE.
- BURST:
  - First beat_valid is in the cycle after acceptance (latency 1); the decode output equals ar_addr in that cycle.
  - beat_last = (beat_idx==len).
  - Handshake occurs when beat_valid & beat_ready.
- dec_select is combinational:
  - dec_select = BURST & beat_ready & !beat_last & burst==INCR & !err.
  - In every other BURST cycle: dec_select=0 and dec_addr=cur_addr, so the decode stage reloads an unchanged value.
  - Result: stalls never advance the address, and there is never a double increment.
- On a handshake of a non-last beat:
  - beat_idx+1.
  - If the burst is INCR and not err: cur_addr += (1<<size), computed modulo 2^ADDR_W, identically to the decode stage. Example: 0xFFFFFFFC+4 = 0x00000000.
- On a handshake of the last beat:
  - Go to IDLE; ar_ready=1 next cycle.
  - One dead cycle between back-to-back bursts.
- FIXED and err bursts: address stays at the start for all len+1 beats.
- err bursts: still produce exactly len+1 beats (protocol completion), each with beat_err=1.
- dec_size = latched size in BURST; ar_size in IDLE.
- 4KB-boundary crossing is not checked; addresses increment arithmetically.
- ar_* inputs are ignored outside IDLE.

Test Plan:
- INCR, addr 0x1000, len=3, size=2, beat_ready=1 -> accept at T, beats T+1..T+4; decode addrs 0x1000/0x1004/0x1008/0x100C; idx 0..3; last only at idx 3; ar_ready=1 at T+5.
- Same burst, beat_ready=0 for 2 cycles at idx 1 -> dec_select=0, dec_addr=0x1004 during stall; decode output holds 0x1004; resumes to 0x1008.
- FIXED, addr 0x20, len=2, size=2 -> 3 beats, all at 0x20; dec_select never 1; beat_err=0.
- ar_burst=10 (then ar_size=3), len=1 -> 2 beats, beat_err=1 on both, address constant at start, last on beat 1.
- rst pulsed one cycle after beat idx 1 handshake of a len=7 INCR -> beat_valid=0 next cycle; ar_ready=1 after release; new INCR burst at 0x40 starts at idx 0 with addr 0x40.
- INCR, addr 0xFFFFFFFC, len=1, size=2 -> addrs 0xFFFFFFFC then 0x00000000; also len=0 -> single beat with beat_last=1 immediately.

Source files
------------

// File: rtl/axi_rd_burst_ctrl.sv
// AXI read-address burst sequencer: accepts one AR request, walks its beats
// and steers the downstream decode stage so its registered address tracks the beat.
module axi_rd_burst_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int MAX_SIZE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              dec_select,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [2:0]        dec_size,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic              beat_last,
  output logic [7:0]        beat_idx,
  output logic              beat_err
);

  // state | meaning
  // IDLE  | waiting for an AR request, ar_ready high
  // BURST | presenting beats 0..len, beat_valid high
  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [2:0] MAX_SZ = 3'(MAX_SIZE);
  localparam logic [1:0] INCR   = 2'b01;

  state_t            state;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              err_q;
  logic [ADDR_W-1:0] step;
  logic              in_burst;

  assign in_burst = (state == BURST);
  assign step     = {{(ADDR_W-1){1'b0}}, 1'b1} << size_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cur_addr <= '0;
      beat_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_valid) begin
            cur_addr <= ar_addr;
            len_q    <= ar_len;
            size_q   <= ar_size;
            burst_q  <= ar_burst;
            beat_idx <= '0;
            err_q    <= ar_burst[1] || (ar_size > MAX_SZ);
            state    <= BURST;
          end
        end
        BURST: begin
          if (beat_ready) begin
            if (beat_last) begin
              state <= IDLE;
            end else begin
              beat_idx <= beat_idx + 8'd1;
              // must match the decode stage's own wrap-around increment
              if (burst_q == INCR && !err_q)
                cur_addr <= cur_addr + step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ar_ready   = (state == IDLE) && !rst;
  assign beat_valid = in_burst;
  assign beat_last  = in_burst && (beat_idx == len_q);
  assign beat_err   = in_burst && err_q;

  // Increment only on a real non-last handshake; every other cycle reloads
  // the unchanged address so stalls can never move the decode output.
  assign dec_select = in_burst && beat_ready && !beat_last && (burst_q == INCR) && !err_q;
  assign dec_addr   = in_burst ? cur_addr : ar_addr;
  assign dec_size   = rst ? 3'd0 : (in_burst ? size_q : ar_size);

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// Directed bench for axi_rd_burst_ctrl with a behavioural model of the
// downstream decode stage's registered address.
module tb_axi_rd_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        dec_select;
  logic [31:0] dec_addr;
  logic [2:0]  dec_size;
  logic        beat_valid;
  logic        beat_ready;
  logic        beat_last;
  logic [7:0]  beat_idx;
  logic        beat_err;

  logic [31:0] dec_q;
  logic [31:0] exp_addr [8];
  int          n_cmp = 0;
  int          n_bad = 0;

  axi_rd_burst_ctrl #(.ADDR_W(32), .MAX_SIZE(2)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .dec_select(dec_select), .dec_addr(dec_addr), .dec_size(dec_size),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_last(beat_last),
    .beat_idx(beat_idx), .beat_err(beat_err)
  );

  always #5 clk = ~clk;

  // decode stage: increment by the beat size or load the presented address
  always @(posedge clk) begin
    if (dec_select) dec_q <= dec_q + (32'd1 << dec_size);
    else            dec_q <= dec_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic err, input int stall_idx, input int stall_n);
    int wait_n = 0;
    logic exp_sel;
    while (!ar_ready && wait_n < 10) begin
      tick();
      wait_n++;
    end
    chk("ar_ready_idle", ar_ready, 1);
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    beat_ready = 1'b1;
    #1;
    chk("dec_addr_pass", dec_addr, addr);
    chk("dec_sel_idle", dec_select, 0);
    chk("dec_size_idle", dec_size, size);
    tick();
    ar_valid = 1'b0; ar_addr = 32'hDEAD_BEE0; ar_len = 8'hFF; ar_size = 3'd0; ar_burst = 2'b01;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stall_idx) begin
        for (int s = 0; s < stall_n; s++) begin
          beat_ready = 1'b0;
          #1;
          chk($sformatf("stall_valid[%0d]", b), beat_valid, 1);
          chk($sformatf("stall_sel[%0d]", b), dec_select, 0);
          chk($sformatf("stall_dec_addr[%0d]", b), dec_addr, exp_addr[b]);
          chk($sformatf("stall_dec_q[%0d]", b), dec_q, exp_addr[b]);
          tick();
        end
      end
      beat_ready = 1'b1;
      #1;
      exp_sel = (burst == 2'b01) && !err && (b != int'(len));
      chk($sformatf("valid[%0d]", b), beat_valid, 1);
      chk($sformatf("idx[%0d]", b), beat_idx, b);
      chk($sformatf("last[%0d]", b), beat_last, b == int'(len));
      chk($sformatf("err[%0d]", b), beat_err, err);
      chk($sformatf("addr[%0d]", b), dec_q, exp_addr[b]);
      chk($sformatf("sel[%0d]", b), dec_select, exp_sel);
      chk($sformatf("size[%0d]", b), dec_size, size);
      chk($sformatf("ar_ready_busy[%0d]", b), ar_ready, 0);
      tick();
    end
    chk("ar_ready_done", ar_ready, 1);
    chk("valid_done", beat_valid, 0);
  endtask

  initial begin
    rst = 1'b1; ar_valid = 1'b0; ar_addr = 32'h0; ar_len = 8'd0;
    ar_size = 3'd2; ar_burst = 2'b01; beat_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_valid", beat_valid, 0);
    chk("rst_last", beat_last, 0);
    chk("rst_err", beat_err, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_sel", dec_select, 0);
    chk("rst_size", dec_size, 0);
    rst = 1'b0;
    #1;
    chk("rel_ar_ready", ar_ready, 1);
    tick();

    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1004; exp_addr[2] = 32'h1008; exp_addr[3] = 32'h100C;
    do_burst(32'h1000, 8'd3, 3'd2, 2'b01, 1'b0, -1, 0);
    do_burst(32'h1000, 8'd3, 3'd2, 2'b01, 1'b0, 1, 2);

    exp_addr[0] = 32'h20; exp_addr[1] = 32'h20; exp_addr[2] = 32'h20;
    do_burst(32'h20, 8'd2, 3'd2, 2'b00, 1'b0, -1, 0);

    exp_addr[0] = 32'h300; exp_addr[1] = 32'h300;
    do_burst(32'h300, 8'd1, 3'd2, 2'b10, 1'b1, -1, 0);
    exp_addr[0] = 32'h400; exp_addr[1] = 32'h400;
    do_burst(32'h400, 8'd1, 3'd3, 2'b01, 1'b1, -1, 0);

    // reset one cycle after the idx 1 handshake of a len=7 INCR burst
    ar_valid = 1'b1; ar_addr = 32'h100; ar_len = 8'd7; ar_size = 3'd2; ar_burst = 2'b01;
    beat_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    chk("rb_idx0", beat_idx, 0);
    tick();
    chk("rb_idx1", beat_idx, 1);
    chk("rb_addr1", dec_q, 32'h104);
    tick();
    rst = 1'b1; beat_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rb_valid", beat_valid, 0);
    chk("rb_last", beat_last, 0);
    chk("rb_err", beat_err, 0);
    chk("rb_idx", beat_idx, 0);
    chk("rb_ar_ready", ar_ready, 1);
    tick();
    exp_addr[0] = 32'h40; exp_addr[1] = 32'h44;
    do_burst(32'h40, 8'd1, 3'd2, 2'b01, 1'b0, -1, 0);

    exp_addr[0] = 32'hFFFF_FFFC; exp_addr[1] = 32'h0000_0000;
    do_burst(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 1'b0, -1, 0);

    exp_addr[0] = 32'h80;
    do_burst(32'h80, 8'd0, 3'd2, 2'b01, 1'b0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
